// File: rtl/riego_pkg.sv
// Shared types and 50 MHz default constants for the watering controller.
package riego_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        REGANDO = 2'd1,
        PAUSA   = 2'd2
    } estado_e;

    localparam int unsigned DEB_CYCLES_DEF = 500_000;
    localparam int unsigned RIEGO_MAX_DEF  = 250_000_000;
    localparam int unsigned PAUSA_CYC_DEF  = 500_000_000;
    localparam int unsigned CNT_W_DEF      = 32;

endpackage

// File: rtl/antirrebote.sv
// Two-flop synchroniser followed by a debouncer; with RIEGO_DEBOUNCE_EN undefined
// the debouncer is removed and the output is the synchronised value.
module antirrebote #(
    parameter int unsigned DEB_CYCLES = 500_000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic sync1_q, sync2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

`ifdef RIEGO_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             held_q, held_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        held_d = held_q;
        cnt_d  = '0;
        if (sync2_q != held_q) begin
            if (cnt_q == DEB_LAST) begin
                held_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            held_q <= held_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = held_q;
`else
    assign dout = sync2_q;
`endif

endmodule

// File: rtl/control_riego.sv
// Watering controller: conditions the three sensor inputs and runs the pump FSM
// (run-time limit plus soak pause). Debouncing is enabled by RIEGO_DEBOUNCE_EN.
module control_riego
    import riego_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned RIEGO_MAX  = RIEGO_MAX_DEF,
    parameter int unsigned PAUSA_CYC  = PAUSA_CYC_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       humedad_raw,
    input  logic       lowLevel_raw,
    input  logic       highLevel_raw,
    input  logic       MODbomba,
    output logic       regar,
    output logic       lowLevel,
    output logic       highLevel,
    output logic       bomba,
    output logic [1:0] estado
);

    localparam logic [CNT_W-1:0] RIEGO_LAST = CNT_W'(RIEGO_MAX - 1);
    localparam logic [CNT_W-1:0] PAUSA_LAST = CNT_W'(PAUSA_CYC - 1);

    antirrebote #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_humedad (
        .clk(clk), .rst(rst), .din(humedad_raw), .dout(regar)
    );
    antirrebote #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_low (
        .clk(clk), .rst(rst), .din(lowLevel_raw), .dout(lowLevel)
    );
    antirrebote #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_high (
        .clk(clk), .rst(rst), .din(highLevel_raw), .dout(highLevel)
    );

    estado_e          estado_q, estado_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             bomba_q, bomba_d;
    logic             arrancar, abortar;

    assign arrancar = regar && MODbomba && lowLevel;
    assign abortar  = !regar || !lowLevel || !MODbomba || highLevel;

    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q + 1'b1;
        case (estado_q)
            REPOSO: begin
                timer_d = '0;
                if (arrancar) estado_d = REGANDO;
            end
            REGANDO: begin
                // Timeout and abort share one exit; the cause is not recorded.
                if (timer_q == RIEGO_LAST || abortar) begin
                    estado_d = PAUSA;
                    timer_d  = '0;
                end
            end
            PAUSA: begin
                if (timer_q == PAUSA_LAST) begin
                    estado_d = REPOSO;
                    timer_d  = '0;
                end
            end
            default: begin
                estado_d = REPOSO;
                timer_d  = '0;
            end
        endcase
        bomba_d = (estado_d == REGANDO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= REPOSO;
            timer_q  <= '0;
            bomba_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            bomba_q  <= bomba_d;
        end
    end

    assign bomba  = bomba_q;
    assign estado = estado_q;

endmodule

// File: tb/tb_control_riego.sv
// Directed bench for control_riego with DEB_CYCLES=4, RIEGO_MAX=20, PAUSA_CYC=10;
// expected latencies follow RIEGO_DEBOUNCE_EN.
module tb_control_riego;

`ifdef RIEGO_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       humedad_raw, lowLevel_raw, highLevel_raw, MODbomba;
    logic       regar, lowLevel, highLevel, bomba;
    logic [1:0] estado;

    int total = 0;
    int bad   = 0;

    control_riego #(
        .DEB_CYCLES(4), .RIEGO_MAX(20), .PAUSA_CYC(10), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .humedad_raw(humedad_raw), .lowLevel_raw(lowLevel_raw),
        .highLevel_raw(highLevel_raw), .MODbomba(MODbomba),
        .regar(regar), .lowLevel(lowLevel), .highLevel(highLevel),
        .bomba(bomba), .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are read 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic changed;

        // Reset held with all raw inputs high.
        rst = 1'b1; humedad_raw = 1'b1; lowLevel_raw = 1'b1; highLevel_raw = 1'b1; MODbomba = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("rst_regar", regar, 0);
        check("rst_low", lowLevel, 0);
        check("rst_high", highLevel, 0);
        check("rst_bomba", bomba, 0);
        check("rst_estado", estado, 0);
        rst = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        check("rise_early_regar", regar, 0);
        tick();
        check("rise_regar", regar, 1);
        check("rise_low", lowLevel, 1);
        check("rise_high", highLevel, 1);

        // Dry soil without pump module: stay idle.
        highLevel_raw = 1'b0;
        for (int i = 0; i < LAT + 1; i++) tick();
        check("nomod_high", highLevel, 0);
        check("nomod_regar", regar, 1);
        check("nomod_bomba", bomba, 0);
        check("nomod_estado", estado, 0);

        // Uninterrupted run, soak pause, restart.
        MODbomba = 1'b1;
        tick();
        check("run_start_estado", estado, 1);
        check("run_start_bomba", bomba, 1);
        n = 1;
        while (bomba && n < 100) begin
            tick();
            if (bomba) n++;
        end
        check("run_len", n, 20);
        check("run_to_pausa", estado, 2);
        n = 1;
        while (estado == 2'd2 && n < 100) begin
            tick();
            if (estado == 2'd2) n++;
        end
        check("pausa_len", n, 10);
        check("pausa_exit_estado", estado, 0);
        check("pausa_exit_bomba", bomba, 0);
        tick();
        check("rerun_estado", estado, 1);
        check("rerun_bomba", bomba, 1);

        // Low tank level drops during pump cycle 5.
        for (int i = 0; i < 4; i++) tick();
        lowLevel_raw = 1'b0;
        n = 0;
        while (bomba && n < 50) begin
            tick();
            n++;
        end
        check("abort_lat", n, LAT + 1);
        check("abort_estado", estado, 2);
        check("abort_low", lowLevel, 0);
        for (int i = 0; i < 12; i++) tick();
        check("abort_idle_estado", estado, 0);
        check("abort_idle_bomba", bomba, 0);

        // Reset pulsed during a run.
        lowLevel_raw = 1'b1;
        n = 0;
        while (estado != 2'd1 && n < 50) begin
            tick();
            n++;
        end
        check("rerun2_estado", estado, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_bomba", bomba, 0);
        check("midrst_estado", estado, 0);
        check("midrst_regar", regar, 0);
        rst = 1'b0;
        MODbomba = 1'b0;
        for (int i = 0; i < LAT + 2; i++) tick();
        check("post_rst_regar", regar, 1);

`ifdef RIEGO_DEBOUNCE_EN
        // Bouncing sensor never passes the debouncer.
        changed = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) humedad_raw = ~humedad_raw;
            tick();
            if (regar !== 1'b1) changed = 1'b1;
        end
        humedad_raw = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            tick();
            if (regar !== 1'b1) changed = 1'b1;
        end
        check("bounce_changed", changed, 0);
        check("bounce_regar", regar, 1);
`else
        // Single-cycle raw pulse passes straight through the synchroniser.
        changed = 1'b0;
        humedad_raw = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pulse_pre", regar, 0);
        humedad_raw = 1'b1;
        tick();
        humedad_raw = 1'b0;
        check("pulse_edge0", regar, 0);
        tick();
        check("pulse_edge1", regar, 1);
        tick();
        check("pulse_edge2", regar, 0);
        check("pulse_changed", changed, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_riego.md
# control_riego

Watering controller that sits directly upstream of the melody alarm blocks and the pump driver. It synchronises and debounces the soil-humidity sensor and the two tank-level probes. It produces the `regar` request and the clean `lowLevel`/`highLevel` levels that the alarms consume. It also runs the pump state machine, which enforces a maximum pump run time and a soak pause between watering cycles.

## Interface
- `DEB_CYCLES`, 500_000: consecutive stable cycles required to accept an input change (10 ms at 50 MHz).
- `RIEGO_MAX`, 250_000_000: maximum cycles `bomba` stays high per cycle (5 s).
- `PAUSA_CYC`, 500_000_000: soak time in cycles after each pump run (10 s).
- `CNT_W`, 32: width of the debounce and state timers. Must hold `max(DEB_CYCLES, RIEGO_MAX, PAUSA_CYC)`.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous reset, active-high.
- `humedad_raw`  in  1  soil sensor digital output, asynchronous; 1 = dry soil.
- `lowLevel_raw`  in  1  5 % tank probe, asynchronous; 1 = water covers probe.
- `highLevel_raw`  in  1  90 % tank probe, asynchronous; 1 = water covers probe.
- `MODbomba`  in  1  pump module present; already synchronous.
- `regar`  out  1  debounced "soil needs water".
- `lowLevel`  out  1  debounced 5 % level.
- `highLevel`  out  1  debounced 90 % level.
- `bomba`  out  1  pump drive, registered.
- `estado`  out  2  current FSM state: 0 REPOSO, 1 REGANDO, 2 PAUSA.

## Operation
- Each raw input passes through a 2-flop synchroniser, then a debouncer.
- Debouncer behaviour:
  - Counter is cleared whenever the synced value equals the held value.
  - Counter increments while they differ.
  - When the counter reaches `DEB_CYCLES-1`, the held value takes the synced value on the next edge and the counter clears.
  - Any bounce back to the held value clears the counter.
- `regar`, `lowLevel` and `highLevel` are the held values of the three debouncers.
- FSM transitions:
  - REPOSO → REGANDO when `regar && MODbomba && lowLevel`. The state timer clears.
  - REGANDO → PAUSA when the timer reaches `RIEGO_MAX-1`, or when `!regar`, `!lowLevel`, `!MODbomba` or `highLevel`. The timer clears.
  - PAUSA → REPOSO when the timer reaches `PAUSA_CYC-1`. All inputs are ignored in PAUSA.
  - Encoding 3 is illegal; it goes to REPOSO next edge with `bomba`=0.
- `bomba` is registered and high iff the next state is REGANDO, so it rises on the same edge that `estado` becomes 1.
- Timeout and abort in the same cycle: go to PAUSA, with no distinction between the two causes.
- Reset values: every output 0, state REPOSO, all counters 0, synchroniser flops 0.
- Reset mid-run drops `bomba` on that edge.

## Timing
- Raw edge at cycle 0 → synced at cycle 2 → debounced output changes at cycle 2+`DEB_CYCLES`, provided the input stays stable.
- Debounced condition true at edge N → `estado`=1 and `bomba`=1 after edge N+1.
- Uninterrupted run: `bomba` high exactly `RIEGO_MAX` cycles.
- PAUSA lasts exactly `PAUSA_CYC` cycles.
- Abort input debounced at edge N → `bomba` low after edge N+1.
- All timers saturate-free. Compares use `==`; the widths guarantee no wrap.

## Configuration
- `RIEGO_DEBOUNCE_EN` defined: full debouncers as above.
- Not defined: debouncers are removed. Outputs equal the 2-flop synchronised values, with 2-cycle latency, and `DEB_CYCLES` is ignored.

## Structure
- Package `riego_pkg`: state enum (`REPOSO`, `REGANDO`, `PAUSA`) and the default constants for 50 MHz.
- Sub-module `antirrebote` (synchroniser plus debouncer, parameter `DEB_CYCLES`), instantiated three times.
- The FSM and state timer live in `control_riego`.

## Test plan
All scenarios use `DEB_CYCLES`=4, `RIEGO_MAX`=20, `PAUSA_CYC`=10.
- Reset held with all raw inputs 1 → all outputs 0 and `estado`=0 while `rst`=1. `regar`/`lowLevel`/`highLevel` rise 6 cycles after `rst` falls.
- `humedad_raw` toggles every 2 cycles for 40 cycles → `regar` never changes.
- Dry soil, `lowLevel_raw`=1, `MODbomba`=1, `highLevel_raw`=0 → `bomba` high exactly 20 cycles, then `estado`=2 for 10 cycles, then REGANDO again.
- `lowLevel_raw` drops at pump cycle 5 → `bomba` falls 7 cycles later (2 sync + 4 debounce + 1 FSM), then PAUSA.
- `MODbomba`=0 with dry soil → `bomba` stays 0, `regar`=1, `estado`=0.
- `rst` pulsed during REGANDO → `bomba`=0 and `estado`=0 on the next edge.
- `RIEGO_DEBOUNCE_EN` undefined → a single-cycle raw pulse appears on `regar` 2 cycles later, 1 cycle wide.
